// File: rtl/rotate_pkg.sv
// Shared definitions for the rotate sequencer and its neighbours.
// Holds the FSM state encoding, rotation direction constants and
// the default pattern / step-count widths.
package rotate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic ROT_LEFT  = 1'b1;
  localparam logic ROT_RIGHT = 1'b0;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/rotate_sequencer.sv
// rotate_sequencer: holds a WIDTH-bit pattern and steps it through an
// external combinational rotator, one rotation per tick, for a commanded
// number of steps.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   load_valid/load_data/load_ready pattern load handshake (IDLE, DONE)
//   cmd_valid/cmd_direction/cmd_distance/cmd_steps/cmd_ready
//                                   rotate command handshake (IDLE only)
//   tick                            step strobe, acts only in RUN
//   halt                            abort run, back to IDLE with state held
//   rot_in/rot_direction/rot_distance  operands to the external rotator
//   rot_out                         rotator result (combinational from rot_in)
//   pattern                         current registered pattern
//   busy, done, steps_left          status: RUN, one-cycle DONE, remaining steps
module rotate_sequencer
  import rotate_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DIST_W = $clog2(WIDTH),
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [WIDTH-1:0]  load_data,
  output logic              load_ready,
  input  logic              cmd_valid,
  input  logic              cmd_direction,
  input  logic [DIST_W-1:0] cmd_distance,
  input  logic [CNT_W-1:0]  cmd_steps,
  output logic              cmd_ready,
  input  logic              tick,
  input  logic              halt,
  output logic [WIDTH-1:0]  rot_in,
  output logic              rot_direction,
  output logic [DIST_W-1:0] rot_distance,
  input  logic [WIDTH-1:0]  rot_out,
  output logic [WIDTH-1:0]  pattern,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  steps_left
);

  state_t              state, state_next;
  logic [WIDTH-1:0]    pattern_next;
  logic [CNT_W-1:0]    steps_next;
  logic                dir_next;
  logic [DIST_W-1:0]   dist_next;
  logic                load_fire;
  logic                cmd_fire;

  // NOTE: every register here is updated with <= so all flops sample the
  // pre-edge values together; blocking assignments would create ordering races.
  // NOTE: all datapath registers are plain flops (no memory array), so they
  // are cleared by the synchronous reset like the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      pattern       <= '0;
      steps_left    <= '0;
      rot_direction <= ROT_RIGHT;
      rot_distance  <= '0;
    end else begin
      state         <= state_next;
      pattern       <= pattern_next;
      steps_left    <= steps_next;
      rot_direction <= dir_next;
      rot_distance  <= dist_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    pattern_next = pattern;
    steps_next   = steps_left;
    dir_next     = rot_direction;
    dist_next    = rot_distance;

    load_ready = (state == ST_IDLE) || (state == ST_DONE);
    cmd_ready  = (state == ST_IDLE);
    load_fire  = load_valid && load_ready;
    cmd_fire   = cmd_valid && cmd_ready;

    unique case (state)
      ST_IDLE: begin
        // A simultaneous load and cmd both take effect; the run then starts
        // from load_data because rot_in follows the freshly loaded pattern.
        if (load_fire) pattern_next = load_data;
        if (cmd_fire) begin
          dir_next   = cmd_direction;
          dist_next  = cmd_distance;
          steps_next = cmd_steps;
          state_next = (cmd_steps != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        // halt wins over tick: abort without touching pattern or count.
        if (halt) begin
          state_next = ST_IDLE;
        end else if (tick) begin
          pattern_next = rot_out;
          steps_next   = steps_left - CNT_W'(1);
          if (steps_left == CNT_W'(1)) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (load_fire) pattern_next = load_data;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rot_in = pattern;
  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_DONE);

endmodule

// File: doc/rotate_sequencer.md
# rotate_sequencer

Sequential controller that drives the combinational rotator stage and registers its result. Holds a WIDTH-bit pattern register, accepts a load and a rotate command (direction, distance, step count), and applies one rotation per `tick` by feeding the pattern to the rotator and capturing the rotator output back into the pattern. This produces the walking-LED / barrel-rotate sequences used downstream by the display logic.

## Interface
Parameters:
- `WIDTH`, 8: pattern width; must be a power of two, ≥ 2.
- `DIST_W`, $clog2(WIDTH) (3): rotate-distance width; distance range 0..WIDTH-1.
- `CNT_W`, 8: step-count width; maximum run length 2^CNT_W-1.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `load_valid` in 1: load request.
- `load_data` in WIDTH: value to load into the pattern.
- `load_ready` out 1: high in IDLE and DONE.
- `cmd_valid` in 1: rotate-command request.
- `cmd_direction` in 1: 1 = left, 0 = right.
- `cmd_distance` in DIST_W: bits rotated per step.
- `cmd_steps` in CNT_W: number of steps.
- `cmd_ready` out 1: high in IDLE only.
- `tick` in 1: step enable, a one-cycle strobe from the beat divider.
- `halt` in 1: abort the current run.
- `rot_in` out WIDTH: to the rotator; equals `pattern`.
- `rot_direction` out 1: latched command direction.
- `rot_distance` out DIST_W: latched command distance.
- `rot_out` in WIDTH: rotator result, combinational from `rot_in`.
- `pattern` out WIDTH: current registered pattern.
- `busy` out 1: state == RUN.
- `done` out 1: state == DONE (one-cycle pulse).
- `steps_left` out CNT_W: remaining steps.

## Operation
- FSM states: IDLE, RUN, DONE.
- A handshake fires when valid && ready in the same cycle.
- **IDLE**
  - Load fires → `pattern` <= `load_data`.
  - Cmd fires → latch direction and distance, `steps_left` <= `cmd_steps`.
    - `cmd_steps` ≠ 0 → go to RUN.
    - `cmd_steps` = 0 → go to DONE with no rotation.
  - Load and cmd in the same cycle: both accepted. The run starts from `load_data`.
- **RUN**
  - Rotation is applied only while in RUN and only on `tick`.
  - `tick` → `pattern` <= `rot_out`, `steps_left` <= `steps_left` - 1.
  - `tick` with `steps_left` == 1 → go to DONE after the final update.
  - `halt` → go to IDLE. No update, no `done`, `pattern` and `steps_left` hold.
  - `halt` has priority over `tick`.
  - `load_valid` is ignored (`load_ready` = 0).
- **DONE**: lasts exactly one cycle, then IDLE. A load is accepted here; a cmd is not.
- `rot_in` = `pattern` at all times.
- `rot_direction` and `rot_distance` hold their latched values until the next accepted cmd.
- Distance 0: each step leaves `pattern` unchanged, but `steps_left` still counts down.
- `tick` outside RUN has no effect.
- `halt` outside RUN has no effect.
- `reset`, including mid-run: next state IDLE; `pattern`, `steps_left`, `rot_direction`, `rot_distance` all 0.

## Timing
- Reset values: `pattern` 0, `rot_in` 0, `rot_direction` 0, `rot_distance` 0, `steps_left` 0, `busy` 0, `done` 0, `load_ready` 1, `cmd_ready` 1.
- Cmd accepted at edge k → `busy` = 1 from edge k. The first `tick` that can act is sampled at edge k+1.
- Tick sampled at edge j → the new `pattern` is visible after edge j.
- Final tick at edge j → `done` = 1 for the cycle after edge j. IDLE and `cmd_ready` = 1 after edge j+1.
- Zero-step cmd at edge k → `done` after edge k.
- Back-to-back ticks: one rotation per cycle.
- The rotator path is combinational inside one cycle; there is no extra pipeline stage.

## Structure
- Shared package `rotate_pkg` holds:
  - the state encoding (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2);
  - direction constants (`ROT_LEFT` = 1, `ROT_RIGHT` = 0);
  - default `WIDTH` and `CNT_W`.
- The rotator itself stays an external sibling instance, wired at the parent through the `rot_*` ports.
- No internal sub-module; the FSM and the down-counter live in this module.

## Test plan
- Load 8'h81, cmd left/1/3, `tick` every cycle → `pattern` 8'h03, 8'h06, 8'h0C on successive cycles; `done` pulses once; `steps_left` ends at 0.
- Load 8'hA5, cmd right/4/2, `tick` every 3 cycles → 8'h5A then 8'hA5; `busy` stays high between ticks.
- Wrap-around: load 8'h01, cmd left/7/1 → 8'h80, the same result as a right rotate by 1.
- `halt` asserted together with the 2nd tick of a 5-step run → `pattern` keeps its 1-step value, `steps_left` = 4, IDLE, no `done`.
- Cmd with steps 0, and separately distance 0 with steps 2 → `pattern` unchanged; `done` after 1 cycle and after 2 ticks respectively.
- `reset` mid-run, plus `load_valid` during RUN → all outputs at reset values; the load during RUN is ignored (`pattern` unchanged).
